// File: rtl/target_table_if.sv
// Bank-switched branch-target table port bundle.
// Lookup, write and bank-select signals grouped with their results.
interface target_table_if #(
  parameter int ADDR_W    = 5,
  parameter int TARGET_W  = 10,
  parameter int NUM_BANKS = 4
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  logic                BankLoad;
  logic [BANK_W-1:0]   BankSel;
  logic                ReqEn;
  logic [ADDR_W-1:0]   Addr;
  logic                WrEn;
  logic [BANK_W-1:0]   WrBank;
  logic [ADDR_W-1:0]   WrAddr;
  logic [TARGET_W-1:0] WrData;
  logic [TARGET_W-1:0] Target;
  logic                Valid;
  logic                Miss;
  logic                Busy;
  logic [BANK_W-1:0]   ActiveBank;

  modport master (
    output BankLoad, BankSel, ReqEn, Addr,
    output WrEn, WrBank, WrAddr, WrData,
    input  Target, Valid, Miss, Busy, ActiveBank
  );

  modport slave (
    input  BankLoad, BankSel, ReqEn, Addr,
    input  WrEn, WrBank, WrAddr, WrData,
    output Target, Valid, Miss, Busy, ActiveBank
  );
endinterface

// File: rtl/target_table.sv
// Banked branch-target table with written flags and a
// one-entry-per-cycle clear sequence after reset.
module target_table #(
  parameter int ADDR_W    = 5,
  parameter int TARGET_W  = 10,
  parameter int NUM_BANKS = 4
) (
  input logic           Clk,
  input logic           Reset,
  target_table_if.slave bus
);
  localparam int BANK_W  = $clog2(NUM_BANKS);
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int ENTRIES = NUM_BANKS * DEPTH;
  localparam int IDX_W   = BANK_W + ADDR_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [IDX_W-1:0]    clr_q;
  logic [IDX_W-1:0]    clr_d;
  logic                clr_we;
  logic [BANK_W-1:0]   bank_q;
  logic [TARGET_W-1:0] tgt_q;
  logic                vld_q;
  logic                miss_q;

  logic [TARGET_W-1:0] data_mem [ENTRIES];
  logic [ENTRIES-1:0]  flag_q;

  logic                idle;
  logic                do_wr;
  logic                do_rd;
  logic                bypass;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    wr_idx;

  assign idle   = (state_q == IDLE);
  assign rd_idx = {bank_q, bus.Addr};
  assign wr_idx = {bus.WrBank, bus.WrAddr};
  assign do_wr  = idle & bus.WrEn & ~Reset;
  assign do_rd  = idle & bus.ReqEn;
  assign bypass = do_wr & (wr_idx == rd_idx);

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    clr_we  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_q == LAST) begin
          state_d = IDLE;
        end else begin
          clr_d = clr_q + IDX_W'(1);
        end
      end
      IDLE: begin
        clr_d = clr_q;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Storage is not reset; the clear walk zeroes it instead.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (clr_we) begin
        data_mem[clr_q] <= '0;
        flag_q[clr_q]   <= 1'b0;
      end else if (do_wr) begin
        data_mem[wr_idx] <= bus.WrData;
        flag_q[wr_idx]   <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      bank_q <= '0;
      tgt_q  <= '0;
      vld_q  <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      vld_q <= do_rd;
      if (idle && bus.BankLoad) begin
        bank_q <= bus.BankSel;
      end
      if (do_rd) begin
        if (bypass) begin
          tgt_q  <= bus.WrData;
          miss_q <= 1'b0;
        end else begin
          tgt_q  <= data_mem[rd_idx];
          miss_q <= ~flag_q[rd_idx];
        end
      end
    end
  end

  assign bus.Target     = tgt_q;
  assign bus.Valid      = vld_q;
  assign bus.Miss       = miss_q;
  assign bus.Busy       = (state_q == CLEAR);
  assign bus.ActiveBank = bank_q;
endmodule

// File: tb/tb_target_table.sv
// Directed bench for target_table with default parameters.
// Inputs change 1ns after a rising edge; outputs sampled there.
module tb_target_table;
  logic clk;
  logic rst;
  int   total;
  int   fails;
  int   nbusy;
  bit   vseen;

  target_table_if #(
    .ADDR_W(5), .TARGET_W(10), .NUM_BANKS(4)
  ) bus ();

  target_table #(
    .ADDR_W(5), .TARGET_W(10), .NUM_BANKS(4)
  ) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.BankLoad = 1'b0;
    bus.BankSel  = '0;
    bus.ReqEn    = 1'b0;
    bus.Addr     = '0;
    bus.WrEn     = 1'b0;
    bus.WrBank   = '0;
    bus.WrAddr   = '0;
    bus.WrData   = '0;
  endtask

  task automatic wr(int b, int a, int d);
    bus.WrEn   = 1'b1;
    bus.WrBank = 2'(b);
    bus.WrAddr = 5'(a);
    bus.WrData = 10'(d);
    step();
    bus.WrEn   = 1'b0;
  endtask

  task automatic load(int b);
    bus.BankLoad = 1'b1;
    bus.BankSel  = 2'(b);
    step();
    bus.BankLoad = 1'b0;
  endtask

  task automatic rd(int a);
    bus.ReqEn = 1'b1;
    bus.Addr  = 5'(a);
    step();
    bus.ReqEn = 1'b0;
  endtask

  // Counts Busy-high samples starting from the reset edge.
  task automatic count_busy(output int n, output bit v);
    n = 0;
    v = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.Busy) break;
      n++;
      if (bus.Valid) v = 1'b1;
      step();
    end
  endtask

  initial begin
    total = 0;
    fails = 0;
    idle_in();
    rst = 1'b1;
    step();
    chk("rst_busy", 32'(bus.Busy), 1);
    chk("rst_valid", 32'(bus.Valid), 0);
    chk("rst_target", 32'(bus.Target), 0);
    chk("rst_miss", 32'(bus.Miss), 0);
    chk("rst_bank", 32'(bus.ActiveBank), 0);

    rst = 1'b0;
    bus.ReqEn    = 1'b1;
    bus.Addr     = 5'd9;
    bus.WrEn     = 1'b1;
    bus.WrBank   = 2'd0;
    bus.WrAddr   = 5'd9;
    bus.WrData   = 10'h155;
    bus.BankLoad = 1'b1;
    bus.BankSel  = 2'd3;
    count_busy(nbusy, vseen);
    idle_in();
    chk("clear_len", 32'(nbusy), 128);
    chk("clear_novalid", 32'(vseen), 0);
    chk("clear_nobank", 32'(bus.ActiveBank), 0);

    rd(3);
    chk("a3_valid", 32'(bus.Valid), 1);
    chk("a3_miss", 32'(bus.Miss), 1);
    chk("a3_target", 32'(bus.Target), 0);
    step();
    chk("pulse_low", 32'(bus.Valid), 0);

    rd(9);
    chk("a9_miss", 32'(bus.Miss), 1);
    chk("a9_target", 32'(bus.Target), 0);

    wr(1, 5, 'h13B);
    load(1);
    chk("bank1", 32'(bus.ActiveBank), 1);
    rd(5);
    chk("b1a5_valid", 32'(bus.Valid), 1);
    chk("b1a5_miss", 32'(bus.Miss), 0);
    chk("b1a5_target", 32'(bus.Target), 'h13B);
    load(0);
    rd(5);
    chk("b0a5_miss", 32'(bus.Miss), 1);
    chk("b0a5_target", 32'(bus.Target), 0);

    bus.ReqEn = 1'b1;
    bus.Addr  = 5'd7;
    wr(0, 7, 'h040);
    bus.ReqEn = 1'b0;
    chk("byp_valid", 32'(bus.Valid), 1);
    chk("byp_target", 32'(bus.Target), 'h040);
    chk("byp_miss", 32'(bus.Miss), 0);
    rd(7);
    chk("a7_target", 32'(bus.Target), 'h040);
    chk("a7_miss", 32'(bus.Miss), 0);

    bus.ReqEn = 1'b1;
    bus.Addr  = 5'd7;
    wr(1, 7, 'h2AA);
    bus.ReqEn = 1'b0;
    chk("nobyp_target", 32'(bus.Target), 'h040);

    wr(2, 0, 'h0AB);
    wr(0, 0, 'h011);
    bus.ReqEn = 1'b1;
    bus.Addr  = 5'd0;
    load(2);
    bus.ReqEn = 1'b0;
    chk("ld_rd_target", 32'(bus.Target), 'h011);
    chk("ld_rd_miss", 32'(bus.Miss), 0);
    chk("ld_rd_bank", 32'(bus.ActiveBank), 2);
    rd(0);
    chk("b2a0_target", 32'(bus.Target), 'h0AB);

    wr(3, 31, 'h3FF);
    load(3);
    rd(31);
    chk("b3a31_target", 32'(bus.Target), 'h3FF);
    chk("b3a31_miss", 32'(bus.Miss), 0);

    rst = 1'b1;
    bus.ReqEn = 1'b1;
    bus.Addr  = 5'd31;
    step();
    bus.ReqEn = 1'b0;
    rst = 1'b0;
    chk("rst2_valid", 32'(bus.Valid), 0);
    chk("rst2_busy", 32'(bus.Busy), 1);
    chk("rst2_bank", 32'(bus.ActiveBank), 0);
    chk("rst2_target", 32'(bus.Target), 0);
    for (int i = 0; i < 40; i++) step();
    chk("mid_busy", 32'(bus.Busy), 1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(nbusy, vseen);
    chk("reclear_len", 32'(nbusy), 128);
    chk("reclear_novalid", 32'(vseen), 0);

    load(3);
    rd(31);
    chk("after_valid", 32'(bus.Valid), 1);
    chk("after_miss", 32'(bus.Miss), 1);
    chk("after_target", 32'(bus.Target), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
